pc_jump: RTL and testbench

Program counter with integrated Hack jump-condition evaluation for the CPU datapath. It sits directly downstream of the ALU status flags (`zr`, `ng`) and the A register. It decodes the three jump bits of a C-instruction with the gate library (`_and`/`_or`/`_not`) and produces the next instruction address for instruction ROM. All outputs are registered.

---
 rtl/pc_jump.sv | 70 +++++++
 tb/tb_pc_jump.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_jump.sv
// Program counter with Hack jump-condition decode: loads the A register value when the
// ALU flags satisfy the C-instruction jump bits, otherwise increments or holds.
module pc_jump #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             jmp_en,
    input  logic [2:0]       j,
    input  logic             zr,
    input  logic             ng,
    input  logic [WIDTH-1:0] target,
    input  logic             inc,
    output logic [WIDTH-1:0] pc,
    output logic             taken
);

    // Gate primitives kept local so the decode reads as the datapath's gate-level netlist.
    function automatic logic _not(input logic a);
        return ~a;
    endfunction

    function automatic logic _and(input logic a, input logic b);
        return a & b;
    endfunction

    function automatic logic _or(input logic a, input logic b);
        return a | b;
    endfunction

    logic ng_n;
    logic zr_n;
    logic jlt;
    logic jeq;
    logic jgt;
    logic cond;
    logic load;

    // With zr = ng = 1 (not produced by a sane ALU), "greater than" is false and the
    // other two terms are evaluated literally.
    assign ng_n = _not(ng);
    assign zr_n = _not(zr);
    assign jlt  = _and(j[2], ng);
    assign jeq  = _and(j[1], zr);
    assign jgt  = _and(j[0], _and(ng_n, zr_n));
    assign cond = _or(_or(jlt, jeq), jgt);
    assign load = _and(jmp_en, cond);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            taken <= 1'b0;
        end else if (clr) begin
            pc    <= '0;
            taken <= 1'b0;
        end else if (load) begin
            pc    <= target;
            taken <= 1'b1;
        end else if (inc) begin
            pc    <= pc + 1'b1;
            taken <= 1'b0;
        end else begin
            taken <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_jump.sv
// Self-checking bench for pc_jump: directed scenarios plus randomized traffic compared
// against a behavioural program-counter model.
module tb_pc_jump;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             jmp_en;
    logic [2:0]       j;
    logic             zr;
    logic             ng;
    logic [WIDTH-1:0] target;
    logic             inc;
    logic [WIDTH-1:0] pc;
    logic             taken;

    int checks;
    int failures;

    logic [WIDTH-1:0] exp_pc;
    logic             exp_taken;

    pc_jump #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .jmp_en (jmp_en),
        .j      (j),
        .zr     (zr),
        .ng     (ng),
        .target (target),
        .inc    (inc),
        .pc     (pc),
        .taken  (taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: does the ALU result satisfy any of the relations the jump bits request?
    function automatic logic wants_jump(input logic [2:0] jb, input logic z, input logic n);
        logic is_less;
        logic is_equal;
        logic is_greater;
        is_less    = n;
        is_equal   = z;
        is_greater = !n && !z;
        return (jb[2] && is_less) || (jb[1] && is_equal) || (jb[0] && is_greater);
    endfunction

    // Advance the model by one edge using the current inputs, then clock the DUT and
    // settle 1 ns past the edge before anyone samples.
    task automatic clock_edge();
        if (!rst_n) begin
            exp_pc    = '0;
            exp_taken = 1'b0;
        end else if (clr) begin
            exp_pc    = '0;
            exp_taken = 1'b0;
        end else if (jmp_en && wants_jump(j, zr, ng)) begin
            exp_pc    = target;
            exp_taken = 1'b1;
        end else if (inc) begin
            exp_pc    = (exp_pc + 1) % (1 << WIDTH);
            exp_taken = 1'b0;
        end else begin
            exp_taken = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr    = 1'b0;
        jmp_en = 1'b0;
        j      = 3'b000;
        zr     = 1'b0;
        ng     = 1'b0;
        target = '0;
        inc    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        inc   = 1'b1;
        rst_n = 1'b0;
        exp_pc    = '0;
        exp_taken = 1'b0;
        #1;
        checks++;
        if (pc !== 16'h0000 || taken !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial pc=%h taken=%b expected pc=0000 taken=0", pc, taken);
        end
        for (int i = 0; i < 3; i++) begin
            clock_edge();
            checks++;
            if (pc !== 16'h0000 || taken !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold[%0d] pc=%h taken=%b expected pc=0000 taken=0", i, pc, taken);
            end
        end
        #3;
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            clock_edge();
            checks++;
            if (pc !== i[WIDTH-1:0] || taken !== 1'b0) begin
                failures++;
                $display("FAIL reset_release_inc[%0d] pc=%h taken=%b expected pc=%h taken=0",
                         i, pc, taken, i[WIDTH-1:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        inc = 1'b1;
        clr = 1'b1;
        clock_edge();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) clock_edge();
        checks++;
        if (pc !== 16'h0005) begin
            failures++;
            $display("FAIL async_setup pc=%h expected 0005", pc);
        end
        // Arm a jump so the lost pending action is also exercised.
        jmp_en = 1'b1;
        j      = 3'b111;
        target = 16'hBEEF;
        #3;
        rst_n = 1'b0;
        exp_pc    = '0;
        exp_taken = 1'b0;
        #1;
        checks++;
        if (pc !== 16'h0000 || taken !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_midcycle pc=%h taken=%b expected pc=0000 taken=0", pc, taken);
        end
        clock_edge();
        checks++;
        if (pc !== 16'h0000 || taken !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_held pc=%h taken=%b expected pc=0000 taken=0", pc, taken);
        end
        #3;
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_decode_sweep();
        logic [1:0] flag_set [3];
        flag_set[0] = 2'b00;
        flag_set[1] = 2'b10;
        flag_set[2] = 2'b01;
        idle_inputs();
        clr = 1'b1;
        clock_edge();
        clr = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int v = 0; v < 8; v++) begin
                logic jumped;
                logic [WIDTH-1:0] prev;
                prev   = pc;
                jmp_en = 1'b1;
                inc    = 1'b1;
                target = 16'h1234;
                j      = v[2:0];
                zr     = flag_set[f][1];
                ng     = flag_set[f][0];
                jumped = wants_jump(j, zr, ng);
                clock_edge();
                checks++;
                if (pc !== exp_pc || taken !== exp_taken
                    || (jumped && pc !== 16'h1234) || (!jumped && pc !== prev + 1'b1)) begin
                    failures++;
                    $display("FAIL decode j=%b zr=%b ng=%b pc=%h taken=%b expected pc=%h taken=%b",
                             j, zr, ng, pc, taken, exp_pc, exp_taken);
                end
                // Step away from the target so a missed jump cannot hide behind a held pc.
                jmp_en = 1'b0;
                clock_edge();
            end
        end
        // Illegal flag pair: less-than and equal fire, greater-than does not.
        for (int v = 0; v < 8; v++) begin
            jmp_en = 1'b1;
            inc    = 1'b1;
            target = 16'h0ABC;
            j      = v[2:0];
            zr     = 1'b1;
            ng     = 1'b1;
            clock_edge();
            checks++;
            if (pc !== exp_pc || taken !== exp_taken) begin
                failures++;
                $display("FAIL decode_illegal j=%b pc=%h taken=%b expected pc=%h taken=%b",
                         j, pc, taken, exp_pc, exp_taken);
            end
        end
        idle_inputs();
    endtask

    task automatic test_gating();
        idle_inputs();
        clr = 1'b1;
        clock_edge();
        clr    = 1'b0;
        jmp_en = 1'b1;
        j      = 3'b111;
        target = 16'h0007;
        clock_edge();
        jmp_en = 1'b0;
        j      = 3'b111;
        target = 16'h4321;
        inc    = 1'b1;
        clock_edge();
        checks++;
        if (pc !== 16'h0008 || taken !== 1'b0) begin
            failures++;
            $display("FAIL gating pc=%h taken=%b expected pc=0008 taken=0", pc, taken);
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        idle_inputs();
        clr    = 1'b1;
        jmp_en = 1'b1;
        j      = 3'b111;
        inc    = 1'b1;
        target = 16'h5555;
        clock_edge();
        checks++;
        if (pc !== 16'h0000 || taken !== 1'b0) begin
            failures++;
            $display("FAIL priority_clr pc=%h taken=%b expected pc=0000 taken=0", pc, taken);
        end
        clr    = 1'b0;
        target = 16'h00FF;
        clock_edge();
        checks++;
        if (pc !== 16'h00FF || taken !== 1'b1) begin
            failures++;
            $display("FAIL priority_load pc=%h taken=%b expected pc=00ff taken=1", pc, taken);
        end
        // Back-to-back jumps keep taken high; the following non-jump edge drops it.
        target = 16'h0100;
        clock_edge();
        checks++;
        if (pc !== 16'h0100 || taken !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back pc=%h taken=%b expected pc=0100 taken=1", pc, taken);
        end
        jmp_en = 1'b0;
        clock_edge();
        checks++;
        if (pc !== 16'h0101 || taken !== 1'b0) begin
            failures++;
            $display("FAIL taken_drop pc=%h taken=%b expected pc=0101 taken=0", pc, taken);
        end
        idle_inputs();
    endtask

    task automatic test_wrap_hold();
        idle_inputs();
        jmp_en = 1'b1;
        j      = 3'b111;
        target = 16'hFFFF;
        clock_edge();
        checks++;
        if (pc !== 16'hFFFF || taken !== 1'b1) begin
            failures++;
            $display("FAIL wrap_load pc=%h taken=%b expected pc=ffff taken=1", pc, taken);
        end
        jmp_en = 1'b0;
        inc    = 1'b1;
        clock_edge();
        checks++;
        if (pc !== 16'h0000 || taken !== 1'b0) begin
            failures++;
            $display("FAIL wrap_inc pc=%h taken=%b expected pc=0000 taken=0", pc, taken);
        end
        inc = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clock_edge();
            checks++;
            if (pc !== 16'h0000 || taken !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d] pc=%h taken=%b expected pc=0000 taken=0", i, pc, taken);
            end
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            clr    = ($urandom_range(0, 15) == 0);
            jmp_en = $urandom_range(0, 1);
            j      = 3'($urandom_range(0, 7));
            zr     = ($urandom_range(0, 3) == 0);
            ng     = $urandom_range(0, 1);
            target = 16'($urandom);
            inc    = ($urandom_range(0, 3) != 0);
            clock_edge();
            checks++;
            if (pc !== exp_pc || taken !== exp_taken) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d] pc=%h taken=%b expected pc=%h taken=%b",
                             i, pc, taken, exp_pc, exp_taken);
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_async_reset();
        test_decode_sweep();
        test_gating();
        test_priority();
        test_wrap_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
